serial_frame_gen: RTL and testbench
===================================

Name: serial_frame_gen

Overview:
Synthesizable, parametrised async-serial frame generator that drives a DUV serial input pin. It generalises fixed 8N1 stimulus to configurable data width, parity, stop bits, runtime baud divisor and a queued multi-frame FIFO. It sits in bench harnesses, or on-chip as a loopback source, feeding a Tiny_PDP port input bit.

Parameters:
DATA_BITS, 8, payload bits per frame (5..9), sent LSB first
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, stop bits per frame (1 or 2)
DIV_W, 16, width of baud_div
FIFO_DEPTH, 4, queued frames (power of 2, >= 2)
GAP_BITS, 0, idle bit-times inserted after each frame's stop bits

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
baud_div  in  DIV_W  clocks per bit; values 0 and 1 clamp to 2
wr_valid  in  1  frame write request
wr_data  in  DATA_BITS  payload to queue
wr_ready  out  1  FIFO can accept a frame
tx  out  1  serial line, registered, idle high
busy  out  1  frame in progress or FIFO non-empty
level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
frame_done  out  1  one-cycle pulse on the last cycle of the final stop/gap bit

Behaviour:
- Reset (rst high at a clk edge): tx=1, busy=0, frame_done=0, level=0, FIFO flushed, FSM=IDLE, counters=0. wr_ready=0 while rst is high.
- Reset mid-frame: abort immediately. tx=1 after the edge. No frame_done pulse.
- Handshake: write occurs when wr_valid && wr_ready. wr_ready = !full && !rst. No write-through when full, even if a pop happens in the same cycle.
- Simultaneous push and pop: level is unchanged.
- FSM states: IDLE, START, DATA, PAR, STOP, GAP.
- IDLE -> START when FIFO non-empty. Pop the head into the shift register and latch the clamped baud_div for the whole frame.
- Latency: write accepted at edge N with FSM idle and FIFO empty; pop at edge N+1; tx=0 from edge N+2.
- Each bit lasts exactly the latched div cycles, using a down-counter reloaded at each bit boundary.
- START: tx=0. DATA: DATA_BITS bits, LSB first.
- PAR: present only if PARITY != 0. Even: parity bit = XOR of the data bits. Odd: its inverse.
- STOP: STOP_BITS bit-times with tx=1.
- GAP: GAP_BITS bit-times with tx=1. Skipped if GAP_BITS=0.
- frame_done pulses on the last cycle of the final STOP or GAP bit.
- Same cycle as frame_done: if the FIFO is non-empty, go directly to START with a new pop, with no idle cycle between frames. Otherwise go to IDLE.
- Changing baud_div mid-frame has no effect until the next frame.
- busy = (FSM != IDLE) || (level != 0).

Optional Feature:
Macro: SERIAL_GEN_ERR_INJECT_EN
- Enabled:
  - Adds inputs inj_parity and inj_stop, sampled with each write and queued alongside the data.
  - inj_parity inverts the transmitted parity bit (ignored if PARITY=0).
  - inj_stop drives the first stop bit low, producing a framing error.
  - frame_done still pulses.
- Disabled: the ports are absent and frames are always well-formed.

Decomposition:
- Package serial_gen_pkg holds:
  - state enum (IDLE/START/DATA/PAR/STOP/GAP);
  - parity code constants PAR_NONE/PAR_ODD/PAR_EVEN;
  - function computing the parity bit from data and mode.
- One sub-module, sync_fifo:
  - parametrised width/depth, synchronous active-high reset;
  - outputs full, empty, level;
  - also reused by other blocks.
- FSM, bit counter and baud counter live in serial_frame_gen.

Test Plan:
1. 8N1, baud_div=4, write 0x75 once -> tx=0 for 4 cycles from edge N+2, then bits 1,0,1,0,1,1,1,0 (4 cycles each), then 1 for 4 cycles; frame_done at cycle N+41; tx stays 1 after.
2. PARITY=2 then PARITY=1, write 0x75 (five ones) -> parity bit 1 for even, 0 for odd; frame length 11 bit-times.
3. FIFO_DEPTH=4, write 6 frames back-to-back -> wr_ready drops after 5 accepted (4 queued + 1 popped); frames emitted contiguously, no idle between stop and next start; level returns to 0 and busy falls with the last frame_done.
4. Assert rst for 1 cycle mid-DATA of frame 2 with 2 queued -> tx=1 next edge, level=0, no frame_done, no further activity.
5. baud_div=0 and =1 -> bit time 2 cycles. baud_div changed 4->8 mid-frame -> current frame stays 4; next frame uses 8.
6. With SERIAL_GEN_ERR_INJECT_EN: 8E1, 0x75, inj_parity=1 -> parity bit 0. inj_stop=1 -> stop bit low for 1 bit-time, then idle high.

Source files
------------

// File: rtl/serial_gen_pkg.sv
// serial_gen_pkg: shared definitions for the serial frame generator.
//   state_t    - frame FSM states (IDLE/START/DATA/PAR/STOP/GAP)
//   PAR_*      - parity mode codes for the PARITY parameter
//   parity_bit - parity bit for a payload, given a parity mode
package serial_gen_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP,
        GAP
    } state_t;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    // Payload is zero-extended to 9 bits; the extra zeros do not change the XOR.
    function automatic logic parity_bit(input logic [8:0] data, input int unsigned mode);
        logic p;
        p = 1'b0;
        if (mode == PAR_EVEN) begin
            p = ^data;
        end else if (mode == PAR_ODD) begin
            p = ~(^data);
        end
        return p;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO, synchronous active-high reset.
// Ports:
//   clk, rst           - clock, synchronous reset (flushes contents)
//   push, push_data    - write request/data; ignored while full
//   pop, pop_data      - read request; pop_data shows the head (valid when !empty)
//   full, empty, level - occupancy status
// DEPTH must be a power of 2 so the pointers wrap naturally.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             do_push;
    logic             do_pop;

    assign full     = (level_q == (AW+1)'(DEPTH));
    assign empty    = (level_q == '0);
    assign level    = level_q;
    assign pop_data = mem_q[rd_ptr_q];

    // Push is gated by the current full flag only, so a pop in the same
    // cycle never lets a write through a full FIFO.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/serial_frame_gen.sv
// serial_frame_gen: queued async-serial frame generator (start, DATA_BITS
// LSB first, optional parity, STOP_BITS stop bits, GAP_BITS idle bit-times).
// Ports:
//   clk, rst       - clock, synchronous active-high reset
//   baud_div       - clocks per bit (0/1 clamp to 2), latched per frame
//   wr_valid/wr_data/wr_ready - frame write handshake into the FIFO
//   tx             - registered serial line, idle high
//   busy           - frame in flight or FIFO non-empty
//   level          - FIFO occupancy
//   frame_done     - pulse on the last cycle of the final stop/gap bit
// Optional macro SERIAL_GEN_ERR_INJECT_EN adds inj_parity / inj_stop inputs,
// queued with each frame, to invert the parity bit / drive the first stop bit low.
module serial_frame_gen
    import serial_gen_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int DIV_W      = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_BITS   = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DIV_W-1:0]              baud_div,
    input  logic                          wr_valid,
    input  logic [DATA_BITS-1:0]          wr_data,
`ifdef SERIAL_GEN_ERR_INJECT_EN
    input  logic                          inj_parity,
    input  logic                          inj_stop,
`endif
    output logic                          wr_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          frame_done
);

`ifdef SERIAL_GEN_ERR_INJECT_EN
    localparam int FW = DATA_BITS + 2;
`else
    localparam int FW = DATA_BITS;
`endif
    localparam int CNT_MAX  = (DATA_BITS > GAP_BITS) ? DATA_BITS : GAP_BITS;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);
    localparam int GAP_LAST = (GAP_BITS == 0) ? 0 : GAP_BITS - 1;

    logic [FW-1:0]        fifo_wdata;
    logic [FW-1:0]        fifo_rdata;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_pop;
    logic                 fifo_push;

    logic [DATA_BITS-1:0] head_data;
    logic                 head_inj_par;
    logic                 head_inj_stop;

    state_t               state_q, state_d;
    logic [DIV_W-1:0]     baud_cnt_q, baud_cnt_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 inj_stop_q, inj_stop_d;
    logic                 tx_q, tx_d;
    logic                 frame_done_q, frame_done_d;

    logic [DIV_W-1:0]     div_clamped;
    logic                 bit_end;
    logic                 end_frame;
    logic                 load;

`ifdef SERIAL_GEN_ERR_INJECT_EN
    assign fifo_wdata    = {inj_stop, inj_parity, wr_data};
    assign head_data     = fifo_rdata[DATA_BITS-1:0];
    assign head_inj_par  = fifo_rdata[DATA_BITS];
    assign head_inj_stop = fifo_rdata[DATA_BITS+1];
`else
    assign fifo_wdata    = wr_data;
    assign head_data     = fifo_rdata;
    assign head_inj_par  = 1'b0;
    assign head_inj_stop = 1'b0;
`endif

    assign wr_ready  = !fifo_full && !rst;
    assign fifo_push = wr_valid && wr_ready;

    sync_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (fifo_wdata),
        .pop       (fifo_pop),
        .pop_data  (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (level)
    );

    assign tx         = tx_q;
    assign frame_done = frame_done_q;
    assign busy       = (state_q != IDLE) || (level != '0);

    assign div_clamped = (baud_div < DIV_W'(2)) ? DIV_W'(2) : baud_div;
    assign bit_end     = (baud_cnt_q == '0);

    always_comb begin
        state_d      = state_q;
        baud_cnt_d   = baud_cnt_q;
        div_d        = div_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        par_d        = par_q;
        inj_stop_d   = inj_stop_q;
        fifo_pop     = 1'b0;
        end_frame    = 1'b0;
        tx_d         = 1'b1;

        // Line level for the bit currently being timed; tx_q is this value
        // delayed one cycle, which gives the two-edge write-to-start latency.
        case (state_q)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_q[0];
            PAR:     tx_d = par_q;
            STOP:    tx_d = !(inj_stop_q && (bit_cnt_q == '0));
            default: tx_d = 1'b1;
        endcase

        if (state_q != IDLE) begin
            if (!bit_end) begin
                baud_cnt_d = baud_cnt_q - DIV_W'(1);
            end else begin
                baud_cnt_d = div_q - DIV_W'(1);
                case (state_q)
                    START: begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end
                    DATA: begin
                        shift_d = shift_q >> 1;
                        if (bit_cnt_q == CNT_W'(DATA_BITS - 1)) begin
                            bit_cnt_d = '0;
                            state_d   = (PARITY != PAR_NONE) ? PAR : STOP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                    end
                    PAR: begin
                        state_d   = STOP;
                        bit_cnt_d = '0;
                    end
                    STOP: begin
                        if (bit_cnt_q == CNT_W'(STOP_BITS - 1)) begin
                            bit_cnt_d = '0;
                            if (GAP_BITS != 0) begin
                                state_d = GAP;
                            end else begin
                                end_frame = 1'b1;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                    end
                    GAP: begin
                        if (bit_cnt_q == CNT_W'(GAP_LAST)) begin
                            bit_cnt_d = '0;
                            end_frame = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end

        // A frame is loaded either from idle or on the final cycle of the
        // previous frame, so queued frames run back to back.
        load = !fifo_empty && ((state_q == IDLE) || end_frame);

        if (load) begin
            fifo_pop   = 1'b1;
            state_d    = START;
            shift_d    = head_data;
            par_d      = (PARITY != PAR_NONE) ?
                         (parity_bit(9'(head_data), PARITY) ^ head_inj_par) : 1'b0;
            inj_stop_d = head_inj_stop;
            div_d      = div_clamped;
            baud_cnt_d = div_clamped - DIV_W'(1);
            bit_cnt_d  = '0;
        end else if (end_frame) begin
            state_d = IDLE;
        end

        frame_done_d = end_frame;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            baud_cnt_q   <= '0;
            div_q        <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_q        <= 1'b0;
            inj_stop_q   <= 1'b0;
            tx_q         <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            baud_cnt_q   <= baud_cnt_d;
            div_q        <= div_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_q        <= par_d;
            inj_stop_q   <= inj_stop_d;
            tx_q         <= tx_d;
            frame_done_q <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_serial_frame_gen.sv
// Self-checking bench for serial_frame_gen: three configurations (8N1,
// 8E2 + 1 gap bit, 8O1 with a 2-deep FIFO) share one stimulus stream and
// are compared every cycle against a frame-level reference model.
module tb_serial_frame_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] baud_div = 16'd4;
    logic        wr_valid = 1'b0;
    logic [7:0]  wr_data = 8'h00;
    logic        inj_parity = 1'b0;
    logic        inj_stop = 1'b0;

    logic        rdy0, rdy1, rdy2;
    logic        tx0, tx1, tx2;
    logic        busy0, busy1, busy2;
    logic        done0, done1, done2;
    logic [2:0]  level0, level1;
    logic [1:0]  level2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    serial_frame_gen #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .DIV_W(16),
                       .FIFO_DEPTH(4), .GAP_BITS(0)) dut0 (
        .clk(clk), .rst(rst), .baud_div(baud_div), .wr_valid(wr_valid), .wr_data(wr_data),
`ifdef SERIAL_GEN_ERR_INJECT_EN
        .inj_parity(inj_parity), .inj_stop(inj_stop),
`endif
        .wr_ready(rdy0), .tx(tx0), .busy(busy0), .level(level0), .frame_done(done0));

    serial_frame_gen #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .DIV_W(16),
                       .FIFO_DEPTH(4), .GAP_BITS(1)) dut1 (
        .clk(clk), .rst(rst), .baud_div(baud_div), .wr_valid(wr_valid), .wr_data(wr_data),
`ifdef SERIAL_GEN_ERR_INJECT_EN
        .inj_parity(inj_parity), .inj_stop(inj_stop),
`endif
        .wr_ready(rdy1), .tx(tx1), .busy(busy1), .level(level1), .frame_done(done1));

    serial_frame_gen #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .DIV_W(16),
                       .FIFO_DEPTH(2), .GAP_BITS(0)) dut2 (
        .clk(clk), .rst(rst), .baud_div(baud_div), .wr_valid(wr_valid), .wr_data(wr_data),
`ifdef SERIAL_GEN_ERR_INJECT_EN
        .inj_parity(inj_parity), .inj_stop(inj_stop),
`endif
        .wr_ready(rdy2), .tx(tx2), .busy(busy2), .level(level2), .frame_done(done2));

    // ---------------- reference model ----------------
    int m_depth [3] = '{4, 4, 2};
    int m_par   [3] = '{0, 2, 1};
    int m_stop  [3] = '{1, 2, 1};
    int m_gap   [3] = '{0, 1, 0};

    logic [9:0]  m_fifo [3][8];   // {inj_stop, inj_parity, data}
    int          m_cnt  [3];
    logic [1:0]  m_wave [3][256]; // per-cycle {tx, frame_done} of frame in flight
    int          m_len  [3];
    int          m_pos  [3];
    logic        m_tx   [3];
    logic        m_done [3];

    task automatic build_frame(input int i, input logic [9:0] e, input int div);
        logic b [16];
        int   nb;
        int   d;
        logic p;
        nb = 0;
        b[nb] = 1'b0; nb++;
        for (int j = 0; j < 8; j++) begin
            b[nb] = e[j]; nb++;
        end
        if (m_par[i] != 0) begin
            p = ^e[7:0];
            if (m_par[i] == 1) p = ~p;
            b[nb] = p ^ e[8]; nb++;
        end
        for (int s = 0; s < m_stop[i]; s++) begin
            b[nb] = (s == 0) ? ~e[9] : 1'b1; nb++;
        end
        for (int g = 0; g < m_gap[i]; g++) begin
            b[nb] = 1'b1; nb++;
        end
        d = (div < 2) ? 2 : div;
        for (int x = 0; x < nb; x++)
            for (int c = 0; c < d; c++)
                m_wave[i][x*d + c] = {b[x], (x == nb-1) && (c == d-1)};
        m_len[i] = nb * d;
        m_pos[i] = 0;
    endtask

    task automatic model_edge();
        logic acc;
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                m_cnt[i] = 0; m_len[i] = 0; m_pos[i] = 0;
                m_tx[i] = 1'b1; m_done[i] = 1'b0;
            end else begin
                acc = wr_valid && (m_cnt[i] < m_depth[i]);
                if (m_pos[i] < m_len[i]) begin
                    {m_tx[i], m_done[i]} = m_wave[i][m_pos[i]];
                    m_pos[i]++;
                end else begin
                    m_tx[i] = 1'b1; m_done[i] = 1'b0;
                end
                if (m_pos[i] >= m_len[i] && m_cnt[i] > 0) begin
                    build_frame(i, m_fifo[i][0], int'(baud_div));
                    for (int k = 0; k < 7; k++) m_fifo[i][k] = m_fifo[i][k+1];
                    m_cnt[i]--;
                end
                if (acc) begin
                    m_fifo[i][m_cnt[i]] = {inj_stop, inj_parity, wr_data};
                    m_cnt[i]++;
                end
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_inst(input int i, input logic t, input logic d, input logic b,
                            input logic r, input int lvl);
        chk($sformatf("tx%0d", i), int'(t), int'(m_tx[i]));
        chk($sformatf("done%0d", i), int'(d), int'(m_done[i]));
        chk($sformatf("busy%0d", i), int'(b), int'((m_pos[i] < m_len[i]) || (m_cnt[i] > 0)));
        chk($sformatf("ready%0d", i), int'(r), int'(!rst && (m_cnt[i] < m_depth[i])));
        chk($sformatf("level%0d", i), lvl, m_cnt[i]);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cmp_inst(0, tx0, done0, busy0, rdy0, int'(level0));
        cmp_inst(1, tx1, done1, busy1, rdy1, int'(level1));
        cmp_inst(2, tx2, done2, busy2, rdy2, int'(level2));
    endtask

    task automatic do_reset();
        rst = 1'b1; wr_valid = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic wr(input logic [7:0] d);
        wr_valid = 1'b1; wr_data = d;
        step();
        wr_valid = 1'b0;
    endtask

    function automatic logic sel_tx(input int i);
        return (i == 0) ? tx0 : (i == 1) ? tx1 : tx2;
    endfunction

    function automatic logic sel_done(input int i);
        return (i == 0) ? done0 : (i == 1) ? done1 : done2;
    endfunction

    typedef struct {
        int   k;     // cycles after the accepting edge
        int   inst;
        logic tx;
        logic done;
    } vec_t;

    vec_t tv [28];
    int   npulse;

    initial begin
        // Single write of 0x75 at baud_div=4: 0x75 LSB first is 1,0,1,0,1,1,1,0.
        tv[0]  = '{1, 0, 1'b1, 1'b0};  tv[1]  = '{2, 0, 1'b0, 1'b0};
        tv[2]  = '{5, 0, 1'b0, 1'b0};  tv[3]  = '{6, 0, 1'b1, 1'b0};
        tv[4]  = '{10, 0, 1'b0, 1'b0}; tv[5]  = '{14, 0, 1'b1, 1'b0};
        tv[6]  = '{18, 0, 1'b0, 1'b0}; tv[7]  = '{22, 0, 1'b1, 1'b0};
        tv[8]  = '{26, 0, 1'b1, 1'b0}; tv[9]  = '{30, 0, 1'b1, 1'b0};
        tv[10] = '{34, 0, 1'b0, 1'b0}; tv[11] = '{38, 0, 1'b1, 1'b0};
        tv[12] = '{40, 0, 1'b1, 1'b0}; tv[13] = '{41, 0, 1'b1, 1'b1};
        tv[14] = '{42, 0, 1'b1, 1'b0}; tv[15] = '{50, 0, 1'b1, 1'b0};
        // 8E2 + 1 gap: even parity of five ones is 1; 13 bit-times.
        tv[16] = '{37, 1, 1'b0, 1'b0}; tv[17] = '{38, 1, 1'b1, 1'b0};
        tv[18] = '{41, 1, 1'b1, 1'b0}; tv[19] = '{52, 1, 1'b1, 1'b0};
        tv[20] = '{53, 1, 1'b1, 1'b1}; tv[21] = '{54, 1, 1'b1, 1'b0};
        // 8O1: odd parity bit is 0; 11 bit-times.
        tv[22] = '{37, 2, 1'b0, 1'b0}; tv[23] = '{38, 2, 1'b0, 1'b0};
        tv[24] = '{41, 2, 1'b0, 1'b0}; tv[25] = '{42, 2, 1'b1, 1'b0};
        tv[26] = '{45, 2, 1'b1, 1'b1}; tv[27] = '{46, 2, 1'b1, 1'b0};

        @(negedge clk);
        do_reset();
        chk("rst_tx", int'(tx0), 1);
        chk("rst_busy", int'(busy0), 0);
        chk("rst_level", int'(level0), 0);
        chk("rst_done", int'(done0), 0);

        // Table-driven single frame
        baud_div = 16'd4;
        wr(8'h75);
        for (int k = 1; k <= 56; k++) begin
            step();
            for (int t = 0; t < 28; t++)
                if (tv[t].k == k) begin
                    chk($sformatf("tbl_tx_k%0d_i%0d", k, tv[t].inst), int'(sel_tx(tv[t].inst)), int'(tv[t].tx));
                    chk($sformatf("tbl_done_k%0d_i%0d", k, tv[t].inst), int'(sel_done(tv[t].inst)), int'(tv[t].done));
                end
        end

        // Six back-to-back writes: 8N1 takes 5 (one popped), then refuses.
        do_reset();
        wr_valid = 1'b1;
        for (int n = 0; n < 6; n++) begin
            wr_data = 8'(8'h30 + n);
            step();
        end
        wr_valid = 1'b0;
        chk("full_ready", int'(rdy0), 0);
        chk("full_level", int'(level0), 4);
        npulse = 0;
        for (int k = 0; k < 260; k++) begin
            step();
            if (done0) npulse++;
        end
        chk("b2b_pulses", npulse, 5);
        chk("b2b_busy", int'(busy0), 0);

        // Reset in the middle of frame 2 with frames still queued
        do_reset();
        for (int n = 0; n < 4; n++) wr(8'(8'hA0 + n));
        for (int k = 0; k < 55; k++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_tx", int'(tx0), 1);
        chk("midrst_level", int'(level0), 0);
        chk("midrst_done", int'(done0), 0);
        npulse = 0;
        for (int k = 0; k < 100; k++) begin
            step();
            if (done0 || !tx0) npulse++;
        end
        chk("midrst_quiet", npulse, 0);

        // baud_div 0 and 1 both clamp to a 2-cycle bit
        for (int b = 0; b < 2; b++) begin
            do_reset();
            baud_div = 16'(b);
            wr(8'h75);
            for (int k = 1; k <= 24; k++) begin
                step();
                if (k == 3)  chk("clamp_start", int'(tx0), 0);
                if (k == 4)  chk("clamp_bit0", int'(tx0), 1);
                if (k == 6)  chk("clamp_bit1", int'(tx0), 0);
                if (k == 21) chk("clamp_done", int'(done0), 1);
            end
        end

        // baud_div change mid-frame only affects the next frame
        do_reset();
        baud_div = 16'd4;
        wr(8'h75);
        wr(8'h0F);
        for (int k = 2; k <= 130; k++) begin
            if (k == 11) baud_div = 16'd8;
            step();
            if (k == 41)  chk("div_f1_done", int'(done0), 1);
            if (k == 120) chk("div_f2_pre", int'(done0), 0);
            if (k == 121) chk("div_f2_done", int'(done0), 1);
        end

`ifdef SERIAL_GEN_ERR_INJECT_EN
        do_reset();
        baud_div = 16'd4;
        inj_parity = 1'b1; inj_stop = 1'b1;
        wr(8'h75);
        inj_parity = 1'b0; inj_stop = 1'b0;
        for (int k = 1; k <= 56; k++) begin
            step();
            if (k == 38) chk("inj_par_e", int'(tx1), 0);
            if (k == 38) chk("inj_stop0", int'(tx0), 0);
            if (k == 41) chk("inj_done0", int'(done0), 1);
            if (k == 42) chk("inj_idle0", int'(tx0), 1);
            if (k == 42) chk("inj_stop1", int'(tx1), 0);
            if (k == 46) chk("inj_stop1b", int'(tx1), 1);
            if (k == 53) chk("inj_done1", int'(done1), 1);
        end
`endif

        // Randomised traffic against the model
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            wr_valid = ($urandom_range(0, 2) == 0);
            wr_data  = 8'($urandom);
`ifdef SERIAL_GEN_ERR_INJECT_EN
            inj_parity = ($urandom_range(0, 3) == 0);
            inj_stop   = ($urandom_range(0, 3) == 0);
`endif
            if ($urandom_range(0, 49) == 0) begin
                case ($urandom_range(0, 4))
                    0: baud_div = 16'd0;
                    1: baud_div = 16'd1;
                    2: baud_div = 16'd2;
                    3: baud_div = 16'd3;
                    default: baud_div = 16'd5;
                endcase
            end
            rst = ($urandom_range(0, 399) == 0);
            step();
        end
        rst = 1'b0;
        wr_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
